// File: rtl/digit_scan_mux.sv
// digit_scan_mux: multiplexes N_DIGITS nibbles onto one display7 decoder with dead-time and frame-coherent updates (option: LEADING_ZERO_BLANK_EN)
module digit_scan_mux #(
    parameter int CLK_HZ   = 27_000_000,
    parameter int FRAME_HZ = 250,
    parameter int N_DIGITS = 4,
    parameter int DEAD_CYC = 64,
    localparam int SLOT_CYC = CLK_HZ / (FRAME_HZ * N_DIGITS),
    localparam int IDX_W    = $clog2(N_DIGITS),
    localparam int CNT_W    = $clog2(SLOT_CYC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [3:0]            digit,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_start
);
    typedef enum logic {DEAD, ON} state_t;
    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx_nx;
    logic                  first, slot_end, wrap;
    logic [4*N_DIGITS-1:0] sh_d, sh_d_nx, act_d, act_d_nx;
    logic [N_DIGITS-1:0]   sh_b, sh_b_nx, act_b, act_b_nx, eff_b;
`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0]   lz;
    logic                  zrun;
`endif

    assign slot_end = (state == ON) && (cnt == CNT_W'(SLOT_CYC - 1));
    assign wrap     = slot_end && (digit_idx == IDX_W'(N_DIGITS - 1));

    // Next-state: the first cycle after reset acts as digit 0's DEAD entry without a data copy
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = digit_idx;
        if (first) begin
            cnt_nx = '0;
        end else if (state == DEAD && cnt == CNT_W'(DEAD_CYC - 1)) begin
            state_nx = ON;
        end else if (slot_end) begin
            state_nx = DEAD;
            cnt_nx   = '0;
            idx_nx   = wrap ? '0 : digit_idx + 1'b1;
        end
    end

    // Shadow captures loads; active takes the shadow (or a same-edge load) only at the frame wrap
    always_comb begin
        sh_d_nx = load ? data_in : sh_d;
        sh_b_nx = load ? blank_mask : sh_b;
`ifdef LEADING_ZERO_BLANK_EN
        lz   = '0;
        zrun = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zrun  = zrun && (sh_d_nx[4*k +: 4] == 4'd0);
            lz[k] = zrun;
        end
        eff_b = sh_b_nx | lz;
`else
        eff_b = sh_b_nx;
`endif
        act_d_nx = wrap ? sh_d_nx : act_d;
        act_b_nx = wrap ? eff_b : act_b;
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DEAD;
            cnt       <= '0;
            digit_idx <= '0;
            first     <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            digit_idx <= idx_nx;
            first     <= 1'b0;
        end
    end

    // Shadow and active data/blank registers; blanks reset dark so nothing shows before a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_d  <= '0;
            sh_b  <= '1;
            act_d <= '0;
            act_b <= '1;
        end else begin
            sh_d  <= sh_d_nx;
            sh_b  <= sh_b_nx;
            act_d <= act_d_nx;
            act_b <= act_b_nx;
        end
    end

    // Registered outputs; digit only moves when index or active data move, both at DEAD entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes      <= '1;
            digit       <= '0;
            frame_start <= 1'b0;
        end else begin
            anodes      <= (state_nx == ON && !act_b_nx[idx_nx]) ? ~(N_DIGITS'(1) << idx_nx) : '1;
            digit       <= act_d_nx[{idx_nx, 2'b00} +: 4];
            frame_start <= first | wrap;
        end
    end
endmodule
